// File: rtl/cp0_exc_seq.sv
// CP0 exception / eret sequencer with mtc0/mfc0 pass-through.
// Drives a single CP0 read port and a single negedge-commit write port.
module cp0_exc_seq #(
  parameter logic [31:0] EXC_VECTOR  = 32'h00400004,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        mtc0_ack,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  output logic        cp0_r,
  output logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_w,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] redirect_pc
);

  typedef enum logic [3:0] {
    IDLE,
    EXC_RS,
    EXC_WS,
    EXC_WC,
    EXC_WE,
    ERET_RS,
    ERET_RE,
    ERET_WS,
    FIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        pad_q, pad_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Next-state, CP0 port drive and CPU-side handshake decode.
  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    epc_d         = epc_q;
    exc_code_d    = exc_code_q;
    exc_pc_d      = exc_pc_q;
    redirect_pc_d = redirect_pc_q;
    pad_d         = pad_q;
    cp0_r         = 1'b0;
    cp0_raddr     = 5'd0;
    cp0_w         = 1'b0;
    cp0_waddr     = 5'd0;
    cp0_wdata     = 32'd0;
    mtc0_ack      = 1'b0;
    mfc0_rdata    = 32'd0;
    unique case (state_q)
      IDLE: begin
        cp0_r      = 1'b1;
        cp0_raddr  = mfc0_addr;
        mfc0_rdata = cp0_rdata;
        if (exc_req) begin
          exc_code_d = exc_code;
          exc_pc_d   = exc_pc;
          state_d    = EXC_RS;
        end else if (eret_req) begin
          pad_d   = 1'b0;
          state_d = ERET_RS;
        end else if (mtc0_req) begin
          cp0_w     = 1'b1;
          cp0_waddr = mtc0_addr;
          cp0_wdata = mtc0_data;
          mtc0_ack  = 1'b1;
        end
      end
      EXC_RS: begin
        cp0_r     = 1'b1;
        cp0_raddr = ADDR_STATUS;
        status_d  = cp0_rdata;
        state_d   = EXC_WS;
      end
      EXC_WS: begin
        cp0_w     = 1'b1;
        cp0_waddr = ADDR_STATUS;
        cp0_wdata = status_q << 5;
        state_d   = EXC_WC;
      end
      EXC_WC: begin
        cp0_w     = 1'b1;
        cp0_waddr = ADDR_CAUSE;
        cp0_wdata = {25'd0, exc_code_q, 2'b00};
        state_d   = EXC_WE;
      end
      EXC_WE: begin
        cp0_w         = 1'b1;
        cp0_waddr     = ADDR_EPC;
        cp0_wdata     = exc_pc_q;
        redirect_pc_d = EXC_VECTOR;
        state_d       = FIN;
      end
      // Status is read on two cycles so eret matches the
      // five-cycle exception latency; reads have no side effect.
      ERET_RS: begin
        cp0_r     = 1'b1;
        cp0_raddr = ADDR_STATUS;
        status_d  = cp0_rdata;
        pad_d     = 1'b1;
        if (pad_q) state_d = ERET_RE;
      end
      ERET_RE: begin
        cp0_r     = 1'b1;
        cp0_raddr = ADDR_EPC;
        epc_d     = cp0_rdata;
        state_d   = ERET_WS;
      end
      ERET_WS: begin
        cp0_w         = 1'b1;
        cp0_waddr     = ADDR_STATUS;
        cp0_wdata     = status_q >> 5;
        redirect_pc_d = epc_q;
        state_d       = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      status_q      <= 32'd0;
      epc_q         <= 32'd0;
      exc_code_q    <= 5'd0;
      exc_pc_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
      pad_q         <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      epc_q         <= epc_d;
      exc_code_q    <= exc_code_d;
      exc_pc_q      <= exc_pc_d;
      redirect_pc_q <= redirect_pc_d;
      pad_q         <= pad_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign redirect_pc = redirect_pc_q;

endmodule
